mips150_lsu: RTL and testbench

//  Parametrised load/store unit between the X stage and the data block RAM. It

---
 rtl/mips150_lsu_if.sv | 43 ++++
 rtl/mips150_lsu.sv | 134 +++++++++++++
 tb/tb_mips150_lsu.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips150_lsu_if.sv
// Request, data-memory and load-response signals of the mips150 load/store unit.
interface mips150_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [1:0]              req_size;
  logic                    req_unsigned;
  logic [ADDR_W-1:0]       req_addr;
  logic [DATA_W-1:0]       req_wdata;
  logic [4:0]              req_rd;

  logic                    mem_en;
  logic [BE_W-1:0]         mem_we;
  logic [ADDR_W-OFF_W-1:0] mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [4:0]              rsp_rd;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output mem_rdata, rsp_ready,
    input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
    input  rsp_valid, rsp_rd, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  mem_rdata, rsp_ready,
    output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
    output rsp_valid, rsp_rd, rsp_data, rsp_err
  );
endinterface

// File: rtl/mips150_lsu.sv
// Load/store unit: byte-enable and lane steering for stores, fixed-latency load
// pipeline with extraction/extension, and a credit-limited in-order response FIFO.
module mips150_lsu #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 14,
  parameter int MEM_LAT   = 1,
  parameter int RSP_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  mips150_lsu_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + MEM_LAT + 1);
  localparam logic [BE_W-1:0]   BE_ONES   = '1;
  localparam logic [DATA_W-1:0] DATA_ONES = '1;

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [4:0]       rd;
    logic [1:0]       size;
    logic             uns;
    logic [OFF_W-1:0] off;
  } metaT;

  typedef struct packed {
    logic              err;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } rspT;

  logic              acc, aligned, sizeLegal, ready, push, pop;
  logic [OFF_W-1:0]  off, alignMask;
  logic [BE_W-1:0]   beMask;
  logic [DATA_W-1:0] dataMask, lane, extData;
  logic [CNT_W-1:0]  inflight, count, credits;
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  metaT              newMeta, tail;
  metaT              pipe [MEM_LAT];
  rspT               pushEntry;
  rspT               fifo [RSP_DEPTH];

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request decode: alignment and the size masks shifted into lanes
  always_comb begin
    off       = bus.req_addr[OFF_W-1:0];
    sizeLegal = (bus.req_size != 2'b11) || (DATA_W == 64);
    alignMask = OFF_W'((1 << bus.req_size) - 1);
    aligned   = sizeLegal && ((off & alignMask) == '0);
    beMask    = ~(BE_ONES << (1 << bus.req_size));
    dataMask  = ~(DATA_ONES << (8 << bus.req_size));
  end

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < MEM_LAT; i++) inflight += CNT_W'(pipe[i].valid);
    credits = inflight + count;
    pop     = (count != '0) && bus.rsp_ready;
    ready   = !rst && ((credits < CNT_W'(RSP_DEPTH)) || pop);
  end

  always_comb begin
    acc           = bus.req_valid && ready;
    bus.req_ready = ready;
    bus.mem_en    = acc && aligned;
    bus.mem_addr  = bus.req_addr[ADDR_W-1:OFF_W];
    bus.mem_we    = (acc && aligned && bus.req_we) ? (beMask << off) : '0;
    bus.mem_wdata = (bus.req_wdata & dataMask) << {off, 3'b000};

    newMeta.valid = acc && !bus.req_we;
    newMeta.err   = !aligned;
    newMeta.rd    = bus.req_rd;
    newMeta.size  = bus.req_size;
    newMeta.uns   = bus.req_unsigned;
    newMeta.off   = off;
  end

  // The last pipeline stage lines up with mem_rdata for its own request
  always_comb begin
    tail = pipe[MEM_LAT-1];
    lane = bus.mem_rdata >> {tail.off, 3'b000};
    case (tail.size)
      2'b00:   extData = tail.uns ? DATA_W'(lane[7:0])  : DATA_W'(signed'(lane[7:0]));
      2'b01:   extData = tail.uns ? DATA_W'(lane[15:0]) : DATA_W'(signed'(lane[15:0]));
      2'b10:   extData = tail.uns ? DATA_W'(lane[31:0]) : DATA_W'(signed'(lane[31:0]));
      default: extData = lane;
    endcase
    push           = tail.valid;
    pushEntry.err  = tail.err;
    pushEntry.rd   = tail.rd;
    pushEntry.data = tail.err ? '0 : extData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= newMeta;
      for (int unsigned i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo[wrPtr] <= pushEntry;
        wrPtr       <= nextPtr(wrPtr);
      end
      if (pop) rdPtr <= nextPtr(rdPtr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    bus.rsp_valid = (count != '0);
    bus.rsp_err   = fifo[rdPtr].err;
    bus.rsp_rd    = fifo[rdPtr].rd;
    bus.rsp_data  = fifo[rdPtr].data;
  end

  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CNT_W'(RSP_DEPTH))));
  assert property (@(posedge clk) disable iff (rst) !(pop && (count == '0)));
endmodule

// File: tb/tb_mips150_lsu.sv
// Self-checking bench for mips150_lsu: directed vector table, multi-cycle
// sequences, and randomized traffic against a byte-array reference model.
module tb_mips150_lsu;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 14;
  localparam int MEM_LAT   = 1;
  localparam int RSP_DEPTH = 4;
  localparam int BE_W      = DATA_W / 8;
  localparam int OFF_W     = $clog2(BE_W);
  localparam int WA_W      = ADDR_W - OFF_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mips150_lsu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mips150_lsu #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErr    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Block RAM stand-in: read-before-write, data returns MEM_LAT cycles later
  logic [DATA_W-1:0] memWords [2**WA_W];
  logic [DATA_W-1:0] rdPipe [MEM_LAT];
  logic [7:0]        refMem [2**ADDR_W];

  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) rdPipe[i] <= rdPipe[i-1];
    rdPipe[0] <= bus.mem_en ? memWords[bus.mem_addr] : DATA_W'(32'hDEADBEEF);
    if (bus.mem_en)
      for (int k = 0; k < BE_W; k++)
        if (bus.mem_we[k]) memWords[bus.mem_addr][8*k +: 8] = bus.mem_wdata[8*k +: 8];
  end
  assign bus.mem_rdata = rdPipe[MEM_LAT-1];

  task automatic preload(input int unsigned w, input logic [DATA_W-1:0] d);
    memWords[w] = d;
    for (int b = 0; b < BE_W; b++) refMem[w*BE_W + b] = d[8*b +: 8];
  endtask

  // Reference model: outstanding loads in order, memory as plain bytes
  typedef struct {
    logic              err;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } rspT;

  rspT               expQ[$];
  rspT               popLog[$];
  bit                stallPrev = 1'b0;
  logic              prevErr;
  logic [4:0]        prevRd;
  logic [DATA_W-1:0] prevData;

  task automatic modelAccept();
    logic [ADDR_W-1:0] a    = bus.req_addr;
    int unsigned       n    = 1 << bus.req_size;
    int unsigned       offs = a % BE_W;
    bit                ok   = !(bus.req_size == 2'b11 && DATA_W == 32) && ((a % n) == 0);
    logic [BE_W-1:0]   expWe = '0;
    logic [63:0]       v = '0;
    rspT               r;
    check("mem_en", 64'(bus.mem_en), 64'(ok));
    check("mem_addr", 64'(bus.mem_addr), 64'(a / BE_W));
    if (bus.req_we) begin
      if (ok)
        for (int unsigned i = 0; i < n; i++) begin
          expWe[offs+i] = 1'b1;
          refMem[a+i]   = bus.req_wdata[8*i +: 8];
          check("mem_wdata_lane", 64'(bus.mem_wdata[8*(offs+i) +: 8]), 64'(bus.req_wdata[8*i +: 8]));
        end
      check("mem_we", 64'(bus.mem_we), 64'(expWe));
    end else begin
      check("mem_we_load", 64'(bus.mem_we), 64'd0);
      r.err  = !ok;
      r.rd   = bus.req_rd;
      r.data = '0;
      if (ok) begin
        for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = refMem[a+i];
        if (!bus.req_unsigned && (8*n < DATA_W) && v[8*n-1]) v = v | (~64'd0 << (8*n));
        r.data = v[DATA_W-1:0];
      end
      expQ.push_back(r);
    end
  endtask

  task automatic monitorStep();
    bit  popNow;
    rspT e;
    if (rst) begin
      expQ.delete();
      stallPrev = 1'b0;
      return;
    end
    popNow = bus.rsp_valid && bus.rsp_ready;
    check("req_ready", 64'(bus.req_ready), 64'((expQ.size() < RSP_DEPTH) || popNow));
    if (stallPrev) begin
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_rsp", {31'd0, bus.rsp_err, bus.rsp_rd, bus.rsp_data[DATA_W-1:0]},
                        {31'd0, prevErr, prevRd, prevData});
    end
    if (popNow) begin
      popLog.push_back('{bus.rsp_err, bus.rsp_rd, bus.rsp_data});
      if (expQ.size() == 0) begin
        nChecks++;
        nErr++;
        $display("FAIL rsp_unexpected: got rd %0d with no load outstanding", bus.rsp_rd);
      end else begin
        e = expQ.pop_front();
        check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        check("rsp_rd", 64'(bus.rsp_rd), 64'(e.rd));
        check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
      end
    end
    if (bus.req_valid && bus.req_ready) modelAccept();
    else check("mem_en_idle", 64'(bus.mem_en), 64'd0);
    stallPrev = bus.rsp_valid && !bus.rsp_ready;
    prevErr   = bus.rsp_err;
    prevRd    = bus.rsp_rd;
    prevData  = bus.rsp_data;
  endtask

  always @(negedge clk) monitorStep();

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                       input logic [4:0] rd, output bit accepted);
    @(posedge clk); #1;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
    @(negedge clk);
    accepted = bus.req_ready;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int c = 0;
    while ((expQ.size() != 0 || bus.rsp_valid) && c < limit) begin
      @(negedge clk);
      c++;
    end
    check("drain_done", 64'(expQ.size()), 64'd0);
  endtask

  // Waits for the response of the request just accepted; lat stays 0 when no response arrives
  task automatic awaitRsp(output int lat, output logic err, output logic [DATA_W-1:0] data);
    lat = 0;
    err = 1'b0;
    data = '0;
    for (int c = 1; c <= MEM_LAT + 3; c++) begin
      @(negedge clk);
      if (bus.rsp_valid && lat == 0) begin
        lat  = c;
        err  = bus.rsp_err;
        data = bus.rsp_data;
      end
    end
  endtask

  typedef struct {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              pre;
    logic [DATA_W-1:0] rdata;
    logic              expEn;
    logic [BE_W-1:0]   expWe;
    logic              expErr;
    logic [DATA_W-1:0] expData;
  } vecT;

  vecT vecs [13];

  initial begin : main
    bit                accepted;
    int                lat, nAcc;
    logic              gotErr;
    logic [DATA_W-1:0] gotData;

    vecs[0]  = '{1'b0, 2'd2, 1'b0, 14'h010, 32'h0,        1'b1, 32'h8899AABB, 1'b1, 4'b0000, 1'b0, 32'h8899AABB};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 14'h013, 32'h0,        1'b1, 32'h80FF1234, 1'b1, 4'b0000, 1'b0, 32'hFFFFFF80};
    vecs[2]  = '{1'b0, 2'd1, 1'b1, 14'h012, 32'h0,        1'b1, 32'h80FF1234, 1'b1, 4'b0000, 1'b0, 32'h000080FF};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 14'h013, 32'h0,        1'b1, 32'h80FF1234, 1'b1, 4'b0000, 1'b0, 32'h00000080};
    vecs[4]  = '{1'b1, 2'd0, 1'b0, 14'h021, 32'hDEAD55A5, 1'b1, 32'h11223344, 1'b1, 4'b0010, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 2'd1, 1'b0, 14'h022, 32'h1234BEEF, 1'b0, 32'h0,        1'b1, 4'b1100, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 14'h020, 32'h0,        1'b0, 32'h0,        1'b1, 4'b0000, 1'b0, 32'hBEEFA544};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 14'h006, 32'h0,        1'b0, 32'h0,        1'b0, 4'b0000, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 14'h025, 32'h55667788, 1'b0, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 2'd3, 1'b0, 14'h008, 32'h0,        1'b0, 32'h0,        1'b0, 4'b0000, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 14'h030, 32'h0,        1'b1, 32'h80017FFF, 1'b1, 4'b0000, 1'b0, 32'h00007FFF};
    vecs[11] = '{1'b0, 2'd1, 1'b0, 14'h032, 32'h0,        1'b0, 32'h0,        1'b1, 4'b0000, 1'b0, 32'hFFFF8001};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 14'h030, 32'h12345678, 1'b0, 32'h0,        1'b1, 4'b1111, 1'b0, 32'h0};

    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_rd = '0;
    bus.rsp_ready = 1'b1;
    for (int unsigned w = 0; w < 2**WA_W; w++) preload(w, DATA_W'($urandom()));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_req_ready", 64'(bus.req_ready), 64'd1);

    // Directed single-request table
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].pre) preload(int'(vecs[i].addr) / BE_W, vecs[i].rdata);
      issue(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, 5'(i + 1), accepted);
      check($sformatf("vec%0d_accept", i), 64'(accepted), 64'd1);
      check($sformatf("vec%0d_mem_en", i), 64'(bus.mem_en), 64'(vecs[i].expEn));
      check($sformatf("vec%0d_mem_we", i), 64'(bus.mem_we), 64'(vecs[i].expWe));
      idle();
      awaitRsp(lat, gotErr, gotData);
      if (vecs[i].we) begin
        check($sformatf("vec%0d_no_rsp", i), 64'(lat), 64'd0);
      end else begin
        check($sformatf("vec%0d_latency", i), 64'(lat), 64'(MEM_LAT + 1));
        check($sformatf("vec%0d_err", i), 64'(gotErr), 64'(vecs[i].expErr));
        check($sformatf("vec%0d_data", i), 64'(gotData), 64'(vecs[i].expData));
      end
      drain(20);
    end

    // Error response stays in order between two good loads
    popLog.delete();
    issue(1'b0, 2'd2, 1'b0, 14'h010, '0, 5'd1, accepted);
    issue(1'b0, 2'd2, 1'b0, 14'h006, '0, 5'd2, accepted);
    issue(1'b0, 2'd2, 1'b0, 14'h014, '0, 5'd3, accepted);
    idle();
    drain(20);
    check("order_count", 64'(popLog.size()), 64'd3);
    if (popLog.size() == 3) begin
      check("order_rd", {49'd0, popLog[0].rd, popLog[1].rd, popLog[2].rd}, {49'd0, 5'd1, 5'd2, 5'd3});
      check("order_err", {61'd0, popLog[0].err, popLog[1].err, popLog[2].err}, 64'b010);
    end

    // Backpressure: credits stop at RSP_DEPTH, a pop frees a same-cycle accept
    popLog.delete();
    bus.rsp_ready = 1'b0;
    nAcc = 0;
    for (int c = 0; c < 8; c++) begin
      issue(1'b0, 2'd2, 1'b0, ADDR_W'(32'h40 + 4*nAcc), '0, 5'(nAcc), accepted);
      if (accepted) nAcc++;
    end
    check("bp_accepted", 64'(nAcc), 64'(RSP_DEPTH));
    check("bp_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_accept", 64'(bus.req_ready), 64'd1);
    idle();
    drain(30);
    check("bp_drained", 64'(popLog.size()), 64'(RSP_DEPTH + 1));
    for (int i = 0; i < popLog.size(); i++)
      check($sformatf("bp_order%0d", i), 64'(popLog[i].rd), 64'(i));

    // Reset with loads in flight and buffered
    preload(32'h50 / BE_W, 32'hCAFEF00D);
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) issue(1'b0, 2'd2, 1'b0, ADDR_W'(32'h40 + 4*c), '0, 5'(c), accepted);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 14'h050, '0, 5'd9, accepted);
    check("rst_fresh_accept", 64'(accepted), 64'd1);
    idle();
    awaitRsp(lat, gotErr, gotData);
    check("rst_fresh_latency", 64'(lat), 64'(MEM_LAT + 1));
    check("rst_fresh_data", 64'(gotData), 64'h00000000CAFEF00D);
    drain(20);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      bus.req_valid    = ($urandom_range(0, 99) < 70);
      bus.req_we       = ($urandom_range(0, 2) == 0);
      bus.req_size     = 2'($urandom_range(0, 3));
      bus.req_unsigned = 1'($urandom_range(0, 1));
      bus.req_addr     = ADDR_W'(32'h100 + $urandom_range(0, 255));
      bus.req_wdata    = DATA_W'($urandom());
      bus.req_rd       = 5'($urandom_range(0, 31));
      bus.rsp_ready    = ($urandom_range(0, 99) < 60);
    end
    idle();
    bus.rsp_ready = 1'b1;
    drain(40);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", nErr, nChecks);
    $fatal(1, "timeout");
  end
endmodule
